// File: rtl/reg_file_pkg.sv
// Shared constants and types for the register file write side.
// Imported by the write decoder and the register bank.
package reg_file_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    typedef logic [DATA_W-1:0] reg_t;

endpackage

// File: rtl/wr_addr_decoder.sv
// Register index to one-hot select, gated by an enable.
// Shared by host writes and the clear sweep.
module wr_addr_decoder
    import reg_file_pkg::*;
#(
    parameter int ADDR_W   = reg_file_pkg::ADDR_W,
    parameter int NUM_REGS = reg_file_pkg::NUM_REGS
) (
    input  logic                en,
    input  logic [ADDR_W-1:0]   addr,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank_writer.sv
// Write side of the register file: byte-enabled valid/ready writes
// plus a one-register-per-cycle clear sweep.
module reg_bank_writer
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = reg_file_pkg::DATA_W,
    parameter int NUM_REGS = reg_file_pkg::NUM_REGS,
    parameter int ADDR_W   = reg_file_pkg::ADDR_W,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [DATA_W/8-1:0]          wr_be,
    output logic                         wr_ack,
    input  logic                         clr_req,
    output logic                         busy,
    output logic                         clr_done,
    output logic [NUM_REGS*DATA_W-1:0]   q_bus
);

    localparam int NB = DATA_W / 8;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_ptr, clr_ptr_nxt;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] sel;
    logic [ADDR_W-1:0]   dec_addr;
    logic                clearing;
    logic                accept;
    logic                last;
    logic                dec_en;

    assign clearing = (state == CLEAR);
    assign wr_ready = (state == IDLE) && !clr_req;
    assign accept   = wr_valid && wr_ready;
    assign last     = clearing && (clr_ptr == ADDR_W'(NUM_REGS - 1));
    assign busy     = clearing;

    // One decoder serves both paths; the sweep owns it while clearing.
    assign dec_addr = clearing ? clr_ptr : wr_addr;
    assign dec_en   = clearing || accept;

    wr_addr_decoder #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_dec (
        .en     (dec_en),
        .addr   (dec_addr),
        .onehot (sel)
    );

    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        unique case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                clr_ptr_nxt = clr_ptr + ADDR_W'(1);
                if (last) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            clr_ptr  <= '0;
            wr_ack   <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_ptr  <= clr_ptr_nxt;
            wr_ack   <= accept;
            clr_done <= last;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (sel[i]) begin
                    if (clearing) begin
                        regs[i] <= RESET_VAL;
                    end else begin
                        for (int k = 0; k < NB; k++) begin
                            if (wr_be[k]) begin
                                regs[i][8*k +: 8] <= wr_data[8*k +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
        assign q_bus[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule
